// File: rtl/mod_sqrt_sched_pkg.sv
// Shared types and constants for the complex-modulus square-root scheduler.
package mod_pkg;
  typedef enum logic [2:0] {
    IDLE, SQ_RE, SQ_IM, START, RUN, STOP, CAPT, DONE
  } state_t;

  localparam int   SQRT_CYCLES_DEF = 32;
  localparam logic ID_A            = 1'b0;
  localparam logic ID_B            = 1'b1;
endpackage

// File: rtl/mod_sqrt_sched_if.sv
// Result channel of mod_sqrt_sched: magnitude plus requester id over valid/ready.
interface mod_sqrt_sched_if #(parameter int DATA_W = 32);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_mag;
  logic              out_id;

  modport master (output out_valid, out_mag, out_id, input out_ready);
  modport slave  (input out_valid, out_mag, out_id, output out_ready);
endinterface

// File: rtl/mod_sqrt_sched_rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins, a tie goes to the one not granted last.
module rr_arb2
  import mod_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);
  assign grant[0] = req[0] & (~req[1] | (last_grant == ID_B));
  assign grant[1] = req[1] & (~req[0] | (last_grant == ID_A));
endmodule

// File: rtl/mod_sqrt_sched.sv
// Arbitrates two requesters onto one shared iterative sqrt datapath and returns
// floor(sqrt(re^2+im^2)) tagged with the requester id.
module mod_sqrt_sched
  import mod_pkg::*;
#(
  parameter int SQRT_CYCLES = SQRT_CYCLES_DEF,
  parameter int DATA_W      = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_a,
  input  logic [DATA_W-1:0]   re_a,
  input  logic [DATA_W-1:0]   im_a,
  output logic                ack_a,
  input  logic                req_b,
  input  logic [DATA_W-1:0]   re_b,
  input  logic [DATA_W-1:0]   im_b,
  output logic                ack_b,
  output logic                sqrt_start,
  output logic                sqrt_stop,
  output logic [2*DATA_W-1:0] sqrt_xin,
  input  logic [DATA_W-1:0]   sqrt_result,
  output logic                busy,
  mod_sqrt_sched_if.master    res
);
  localparam int CNT_W = $clog2(SQRT_CYCLES + 1);

  state_t              state, state_nxt;
  logic [1:0]          grant;
  logic                take, grant_id, last_grant, out_id_q;
  logic [DATA_W-1:0]   sel_re, sel_im, mag_re, mag_im, mul_op, out_mag_q;
  logic [2*DATA_W-1:0] acc, prod;
  logic [CNT_W-1:0]    cnt;

  // Two's complement magnitude; the most negative value maps to 2^(DATA_W-1).
  function automatic logic [DATA_W-1:0] abs_w(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? -x : x;
  endfunction

  rr_arb2 u_arb (.req({req_b, req_a}), .last_grant(last_grant), .grant(grant));

  assign take     = (state == IDLE) && !reset && (|grant);
  assign grant_id = grant[1];
  assign sel_re   = grant[1] ? re_b : re_a;
  assign sel_im   = grant[1] ? im_b : im_a;

  // One multiplier squares |re| then |im| on consecutive cycles.
  assign mul_op = (state == SQ_IM) ? mag_im : mag_re;
  assign prod   = {{DATA_W{1'b0}}, mul_op} * {{DATA_W{1'b0}}, mul_op};

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ack_a      = 1'b0;
    ack_b      = 1'b0;
    sqrt_start = 1'b0;
    sqrt_stop  = 1'b0;
    case (state)
      IDLE:  if (take) begin
               state_nxt = SQ_RE;
               ack_a     = grant[0];
               ack_b     = grant[1];
             end
      SQ_RE: state_nxt = SQ_IM;
      SQ_IM: state_nxt = START;
      START: begin sqrt_start = 1'b1; state_nxt = RUN; end
      RUN:   if (cnt == '0) state_nxt = STOP;
      STOP:  begin sqrt_stop = 1'b1; state_nxt = CAPT; end
      CAPT:  state_nxt = DONE;
      DONE:  if (res.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= ID_B;
      mag_re     <= '0;
      mag_im     <= '0;
      acc        <= '0;
      cnt        <= '0;
      out_mag_q  <= '0;
      out_id_q   <= ID_A;
    end else begin
      if (take) begin
        last_grant <= grant_id;
        out_id_q   <= grant_id;
        mag_re     <= abs_w(sel_re);
        mag_im     <= abs_w(sel_im);
      end
      case (state)
        SQ_RE:   acc       <= prod;
        SQ_IM:   acc       <= acc + prod;
        START:   cnt       <= CNT_W'(SQRT_CYCLES - 1);
        RUN:     cnt       <= cnt - CNT_W'(1);
        CAPT:    out_mag_q <= sqrt_result;
        default: ;
      endcase
    end
  end

  assign sqrt_xin      = acc;
  assign busy          = (state != IDLE);
  assign res.out_valid = (state == DONE);
  assign res.out_mag   = out_mag_q;
  assign res.out_id    = out_id_q;
endmodule

// File: tb/tb_mod_sqrt_sched.sv
// Scoreboard bench for mod_sqrt_sched with a behavioural floor-sqrt datapath.
module tb_mod_sqrt_sched;
  localparam int SQ = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [31:0] re_a = '0, im_a = '0, re_b = '0, im_b = '0;
  logic        ack_a, ack_b, sqrt_start, sqrt_stop, busy;
  logic [63:0] sqrt_xin;
  logic [31:0] sqrt_result = '0;

  typedef struct { logic id; logic [31:0] mag; } exp_t;
  exp_t sb[$];
  int   n_chk = 0, n_fail = 0;

  mod_sqrt_sched_if #(.DATA_W(32)) res_if ();

  mod_sqrt_sched #(.SQRT_CYCLES(SQ), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .req_a(req_a), .re_a(re_a), .im_a(im_a), .ack_a(ack_a),
    .req_b(req_b), .re_b(re_b), .im_b(im_b), .ack_b(ack_b),
    .sqrt_start(sqrt_start), .sqrt_stop(sqrt_stop), .sqrt_xin(sqrt_xin),
    .sqrt_result(sqrt_result), .busy(busy), .res(res_if)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] isqrt(input logic [63:0] x);
    logic [63:0] r, t;
    r = '0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= x) r = t;
    end
    return r[31:0];
  endfunction

  function automatic logic [31:0] ref_mag(input logic [31:0] re, input logic [31:0] im);
    longint sr, si;
    logic [63:0] a, b;
    sr = longint'($signed(re)); if (sr < 0) sr = -sr;
    si = longint'($signed(im)); if (si < 0) si = -si;
    a = sr; b = si;
    return isqrt(a * a + b * b);
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'h0;
      2: return 32'h7fff_ffff;
      3: return 32'hffff_ffff;
      default: return $urandom();
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Behavioural sqrt_datapath: result register loads on the stop strobe.
  always @(posedge clock) if (sqrt_stop) sqrt_result <= isqrt(sqrt_xin);

  // Scoreboard: push on ack, pop on output handshake.
  always @(negedge clock) begin
    if (!reset) begin
      if (ack_a || ack_b) chk("ack_onehot", {62'd0, ack_a, ack_b}, ack_a ? 64'd2 : 64'd1);
      if (sqrt_start || sqrt_stop) chk("start_stop_excl", 64'(sqrt_start & sqrt_stop), 0);
      if (ack_a)      sb.push_back('{1'b0, ref_mag(re_a, im_a)});
      else if (ack_b) sb.push_back('{1'b1, ref_mag(re_b, im_b)});
      if (res_if.out_valid && res_if.out_ready) begin
        if (sb.size() == 0) chk("sb_unexpected_result", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_id", 64'(res_if.out_id), 64'(e.id));
          chk("sb_mag", 64'(res_if.out_mag), 64'(e.mag));
        end
      end
    end
  end

  // Waits for the next ack; k is the number of cycles after the call's cycle.
  task automatic wait_ack(input string tag, output int k, output logic got_b);
    bit found = 0;
    k = -1; got_b = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clock);
      if (ack_a || ack_b) begin found = 1; k = i; got_b = ack_b; end
    end
    if (!found) chk({tag, "_ack_timeout"}, 0, 1);
  endtask

  // Called at the ack cycle's negedge: drops the acked request, checks timing and result.
  task automatic wait_result(input bit drop_a, input bit drop_b, input logic exp_id,
                             input logic [31:0] exp_mag, input logic [63:0] exp_xin,
                             input string tag);
    int t_start = -1, t_stop = -1;
    bit found = 0;
    for (int k = 1; k < 200 && !found; k++) begin
      @(posedge clock); #1;
      if (k == 1) begin
        if (drop_a) req_a = 1'b0;
        if (drop_b) req_b = 1'b0;
      end
      @(negedge clock);
      if (sqrt_start && t_start < 0) begin
        t_start = k;
        chk({tag, "_xin"}, sqrt_xin, exp_xin);
      end
      if (sqrt_stop && t_stop < 0) t_stop = k;
      if (res_if.out_valid) begin
        found = 1;
        chk({tag, "_t_start"}, 64'(t_start), 3);
        chk({tag, "_t_stop"}, 64'(t_stop), SQ + 4);
        chk({tag, "_latency"}, 64'(k), SQ + 6);
        chk({tag, "_mag"}, 64'(res_if.out_mag), 64'(exp_mag));
        chk({tag, "_id"}, 64'(res_if.out_id), 64'(exp_id));
      end
    end
    if (!found) chk({tag, "_valid_timeout"}, 0, 1);
  endtask

  initial begin
    int   k;
    logic gb;
    int   acks, cyc;
    bit   pa, pb;

    res_if.out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_valid", 64'(res_if.out_valid), 0);
    chk("rst_mag", 64'(res_if.out_mag), 0);
    chk("rst_id", 64'(res_if.out_id), 0);
    chk("rst_xin", sqrt_xin, 0);
    chk("rst_strobes", 64'({sqrt_start, sqrt_stop, ack_a, ack_b}), 0);

    // Both requesters from reset: A first, then B.
    @(posedge clock); #1;
    req_a = 1; re_a = -32'sd6; im_a = 32'sd8;
    req_b = 1; re_b = 32'sd5;  im_b = 32'sd12;
    wait_ack("tie1", k, gb);
    chk("tie1_winner_a", 64'(gb), 0);
    wait_result(1, 0, 1'b0, 32'd10, 64'd100, "tie1_a");
    wait_ack("tie1b", k, gb);
    chk("tie1_winner_b", 64'(gb), 1);
    chk("tie1_b_next_cycle", 64'(k), 0);
    wait_result(0, 1, 1'b1, 32'd13, 64'd169, "tie1_b");

    repeat (3) @(posedge clock);
    #1 req_a = 1; req_b = 1;
    wait_ack("tie2", k, gb);
    chk("tie2_winner_a", 64'(gb), 0);
    wait_result(1, 0, 1'b0, 32'd10, 64'd100, "tie2_a");
    wait_ack("tie2b", k, gb);
    chk("tie2_winner_b", 64'(gb), 1);
    wait_result(0, 1, 1'b1, 32'd13, 64'd169, "tie2_b");

    // Single A request with full timing.
    @(posedge clock); #1;
    req_a = 1; re_a = 32'd3; im_a = 32'd4;
    wait_ack("single", k, gb);
    chk("single_ack_cycle0", 64'(k), 0);
    chk("single_is_a", 64'(gb), 0);
    wait_result(1, 0, 1'b0, 32'd5, 64'd25, "single");

    // Extremes: most negative operands and zero.
    @(posedge clock); #1;
    req_a = 1; re_a = 32'h8000_0000; im_a = 32'h8000_0000;
    wait_ack("maxneg", k, gb);
    wait_result(1, 0, 1'b0, 32'd3037000499, 64'h8000_0000_0000_0000, "maxneg");
    @(posedge clock); #1;
    req_a = 1; re_a = 32'd0; im_a = 32'd0;
    wait_ack("zero", k, gb);
    wait_result(1, 0, 1'b0, 32'd0, 64'd0, "zero");

    // Backpressure in DONE with B pending.
    @(posedge clock); #1;
    res_if.out_ready = 0;
    req_a = 1; re_a = 32'd9; im_a = -32'sd12;
    wait_ack("stall", k, gb);
    wait_result(1, 0, 1'b0, 32'd15, 64'd225, "stall");
    @(posedge clock); #1;
    req_b = 1; re_b = 32'd8; im_b = 32'd15;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("stall_valid", 64'(res_if.out_valid), 1);
      chk("stall_mag", 64'(res_if.out_mag), 15);
      chk("stall_id", 64'(res_if.out_id), 0);
      chk("stall_no_ack_b", 64'(ack_b), 0);
      if (i < 9) begin @(posedge clock); #1; end
    end
    @(posedge clock); #1 res_if.out_ready = 1;
    @(negedge clock);
    chk("hs_cycle_no_ack_b", 64'(ack_b), 0);
    wait_ack("after_hs", k, gb);
    chk("after_hs_is_b", 64'(gb), 1);
    chk("after_hs_next_cycle", 64'(k), 0);
    wait_result(0, 1, 1'b1, 32'd17, 64'd289, "after_hs");

    // Reset during RUN discards the result and restores arbitration priority.
    @(posedge clock); #1;
    req_a = 1; re_a = 32'd1; im_a = 32'd1;
    wait_ack("rstrun", k, gb);
    @(posedge clock); #1 req_a = 0;
    repeat (10) @(posedge clock);
    #1 reset = 1; sb.delete();
    @(posedge clock); #1 reset = 0;
    @(negedge clock);
    chk("rstrun_busy", 64'(busy), 0);
    chk("rstrun_valid", 64'(res_if.out_valid), 0);
    chk("rstrun_mag", 64'(res_if.out_mag), 0);
    chk("rstrun_xin", sqrt_xin, 0);
    chk("rstrun_strobes", 64'({sqrt_start, sqrt_stop, ack_a, ack_b}), 0);
    @(posedge clock); #1;
    req_a = 1; re_a = 32'd7;  im_a = 32'd24;
    req_b = 1; re_b = 32'd20; im_b = 32'd21;
    wait_ack("post_rst", k, gb);
    chk("post_rst_winner_a", 64'(gb), 0);
    wait_result(1, 0, 1'b0, 32'd25, 64'd625, "post_rst_a");
    wait_ack("post_rst_b", k, gb);
    chk("post_rst_winner_b", 64'(gb), 1);
    wait_result(0, 1, 1'b1, 32'd29, 64'd841, "post_rst_b");

    // Random traffic against the scoreboard.
    acks = 0; cyc = 0;
    while (acks < 1000 && cyc < 85000) begin
      @(negedge clock);
      pa = ack_a; pb = ack_b;
      acks += int'(pa) + int'(pb);
      @(posedge clock); #1;
      cyc++;
      if (pa || (req_a && $urandom_range(0, 63) == 0)) req_a = 0;
      else if (!req_a && $urandom_range(0, 3) == 0) begin
        req_a = 1; re_a = rnd_op(); im_a = rnd_op();
      end
      if (pb || (req_b && $urandom_range(0, 63) == 0)) req_b = 0;
      else if (!req_b && $urandom_range(0, 3) == 0) begin
        req_b = 1; re_b = rnd_op(); im_b = rnd_op();
      end
      res_if.out_ready = ($urandom_range(0, 2) != 0);
    end
    chk("rand_acks_reached", 64'(acks >= 1000), 1);
    req_a = 0; req_b = 0; res_if.out_ready = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (!busy) break;
    end
    chk("rand_idle", 64'(busy), 0);
    chk("rand_sb_empty", 64'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mod_sqrt_sched.md
Name: mod_sqrt_sched

Overview:
- Controller and arbiter for a single shared iterative square-root datapath (sqrt_datapath) used to compute complex modulus |z| = sqrt(re² + im²).
- Two requesters (operand A path, operand B path) compete for the datapath under round-robin arbitration.
- Computes the 64-bit radicand with one shared multiplier, then sequences the datapath's start/stop strobes and returns a 32-bit magnitude over a valid/ready handshake tagged with the requester id.

Parameters:
- SQRT_CYCLES, 32, number of iteration cycles sqrt_datapath needs between start and stop (≥1).
- DATA_W, 32, width of the re/im operands and of the magnitude.

Ports:
- clock  in  1  master clock.
- reset  in  1  synchronous, active-high reset.
- req_a  in  1  requester A wants a modulus (level).
- re_a  in  DATA_W  requester A real part, two's complement.
- im_a  in  DATA_W  requester A imaginary part, two's complement.
- ack_a  out  1  one-cycle pulse: A's operands captured this edge.
- req_b, re_b, im_b, ack_b: same as the A ports, for requester B.
- sqrt_start  out  1  start strobe to sqrt_datapath.
- sqrt_stop  out  1  stop/load strobe to sqrt_datapath.
- sqrt_xin  out  2*DATA_W  radicand to sqrt_datapath.
- sqrt_result  in  DATA_W  sqrt_datapath output register.
- out_valid  out  1  magnitude available.
- out_ready  in  1  consumer accepts the magnitude.
- out_mag  out  DATA_W  floor(sqrt(re²+im²)).
- out_id  out  1  0 = A, 1 = B.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = B, so A wins the first tie.
- States: IDLE, SQ_RE, SQ_IM, START, RUN, STOP, CAPT, DONE.
- IDLE arbitration:
  - If exactly one request is present, grant it.
  - If both are present, grant the one that is not last_grant.
  - On grant: pulse that requester's ack, capture |re| and |im| (DATA_W-bit unsigned magnitude; |−2^(DATA_W−1)| = 2^(DATA_W−1)), record the id, update last_grant, go to SQ_RE.
  - No request: stay in IDLE.
- SQ_RE: acc <= |re|². Next state SQ_IM.
- SQ_IM: acc <= acc + |im|². The sum is at most 2^63, so it fits 2*DATA_W bits with no overflow. Next state START.
- START: sqrt_start = 1 for one cycle. Load the iteration counter with SQRT_CYCLES−1. Next state RUN.
- RUN: count down; leave for STOP after the cycle in which the counter is 0. RUN lasts exactly SQRT_CYCLES cycles.
- STOP: sqrt_stop = 1 for one cycle. Next state CAPT.
- CAPT: out_mag <= sqrt_result. Next state DONE.
- DONE: out_valid = 1. out_mag and out_id are held stable. Return to IDLE on the cycle where out_valid && out_ready.
- sqrt_xin is driven from acc and stays stable from START through CAPT.
- Latency: counting the ack cycle as 0, out_valid is first high in cycle SQRT_CYCLES+6 (38 at default).
- A request raised while busy is not acked until the controller returns to IDLE. Operands are sampled only on the ack edge.
- A request dropped before ack leaves no trace.
- A new grant is possible in the cycle immediately after the DONE handshake (the IDLE cycle).
- Reset asserted in any state:
  - Return to IDLE next edge with all outputs cleared; the in-flight result is discarded.
  - sqrt_start/sqrt_stop deassert the same edge.
  - last_grant returns to B.
- Invariants:
  - ack_a and ack_b are never high together.
  - sqrt_start and sqrt_stop are never high together.

Decomposition:
- Shared package mod_pkg:
  - state enum: IDLE..DONE.
  - default SQRT_CYCLES constant.
  - requester id constants: ID_A = 0, ID_B = 1.
- One natural sub-module: rr_arb2.
  - Inputs: req[1:0], last_grant.
  - Outputs: one-hot grant.
  - Purely combinational, reusable by other shared units.
- sqrt_datapath stays external; it is wired at the parent level.

Test Plan:
- Bench uses a behavioural sqrt model that loads floor(sqrt(xin)) on stop.
- Single A request, re_a=3, im_a=4, out_ready=1 → ack_a in cycle 0, sqrt_start in cycle 3, sqrt_stop in cycle 36, sqrt_xin=25, out_valid in cycle 38 with out_mag=5, out_id=0.
- req_a and req_b both raised from reset, A=(−6,8), B=(5,12) → A served first (mag 10, id 0), then B (mag 13, id 1). Raising both again later serves A, alternating correctly.
- re=im=−2^31 → sqrt_xin = 2^63, out_mag = 3037000499. re=im=0 → out_mag = 0.
- out_ready held 0 for 10 cycles in DONE → out_valid, out_mag, out_id stable; req_b pending is not acked until the cycle after the handshake.
- Reset pulsed during RUN → next cycle IDLE, busy=0, all outputs 0. A fresh request (7,24) then completes with mag 25 at the normal latency.
- Random: 1000 random operand pairs, random req/ready timing → every ack matched by exactly one result with the correct id and floor-sqrt value; no simultaneous acks.
